// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - multicycle RV32I control FSM and ALUCtrl decoder.
// Optional performance counters are built in when RVCTRL_PERF_COUNTERS_EN is defined.
module rv_multicycle_ctrl #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            Comparison,
    input  logic            mem_ready,
    output logic            PCUpdate,
    output logic            PCWrite,
    output logic            AdrSrc,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            RegWrite,
    output logic [1:0]      ResultSrc,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [2:0]      ImmSrc,
    output logic [3:0]      ALUCtrl,
    output logic            illegal_instr,
    output logic [3:0]      state_o
`ifdef RVCTRL_PERF_COUNTERS_EN
    ,
    output logic [WIDTH-1:0] cycle_count,
    output logic [WIDTH-1:0] instret_count
`endif
);

    localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_STORE  = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_R      = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_I      = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OP_JAL    = OP_W'(7'b1101111);
    localparam logic [OP_W-1:0] OP_JALR   = OP_W'(7'b1100111);
    localparam logic [OP_W-1:0] OP_LUI    = OP_W'(7'b0110111);
    localparam logic [OP_W-1:0] OP_AUIPC  = OP_W'(7'b0010111);

    localparam logic [3:0] ALU_ADD = 4'b0010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_ILLEGAL  = 4'd15
    } state_t;

    state_t state, next_state;

    // I-type differs from R-type only in that funct3=000 never means SUB.
    function automatic logic [3:0] arith_code(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'b000:  arith_code = (is_r && f7) ? 4'b0110 : 4'b0010;
            3'b001:  arith_code = 4'b1000;
            3'b010:  arith_code = 4'b0100;
            3'b011:  arith_code = 4'b0011;
            3'b100:  arith_code = 4'b1001;
            3'b101:  arith_code = f7 ? 4'b1011 : 4'b1010;
            3'b110:  arith_code = 4'b0001;
            default: arith_code = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] branch_code(input logic [2:0] f3);
        case (f3)
            3'b000:  branch_code = 4'b1100;
            3'b001:  branch_code = 4'b1101;
            3'b100:  branch_code = 4'b1110;
            3'b101:  branch_code = 4'b1111;
            3'b110:  branch_code = 4'b0101;
            3'b111:  branch_code = 4'b0111;
            default: branch_code = 4'b0010;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXECR;
                    OP_I:              next_state = S_EXECI;
                    OP_BRANCH:         next_state = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    default:           next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC: next_state = S_ALUWB;
            S_JALR:     next_state = S_LINK;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        PCUpdate      = 1'b0;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        illegal_instr = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUCtrl       = ALU_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
            end
            S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
            S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUCtrl = arith_code(funct3, funct7b5, 1'b1);
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUCtrl = arith_code(funct3, funct7b5, 1'b0);
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUCtrl = branch_code(funct3);
            end
            S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCUpdate = 1'b1; end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCUpdate  = 1'b1;
            end
            S_LINK: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
            end
            S_LUI:      begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
            S_AUIPC:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            default:    illegal_instr = 1'b1;
        endcase
        PCWrite = PCUpdate | ((state == S_BRANCH) & Comparison);
        // Any in-flight write is dropped while reset is asserted.
        if (reset) begin
            PCUpdate      = 1'b0;
            PCWrite       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_I, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:               ImmSrc = 3'b001;
            OP_BRANCH:              ImmSrc = 3'b010;
            OP_LUI, OP_AUIPC:       ImmSrc = 3'b011;
            OP_JAL:                 ImmSrc = 3'b100;
            default:                ImmSrc = 3'b000;
        endcase
    end

    assign state_o = state;

`ifdef RVCTRL_PERF_COUNTERS_EN
    // An instruction retires when it returns to FETCH, unless it was rejected as illegal.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
            if (next_state == S_FETCH && state != S_FETCH && state != S_ILLEGAL) begin
                instret_count <= instret_count + 1'b1;
            end
        end
    end
`else
    logic unused_width;
    assign unused_width = (WIDTH != 0);
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - scoreboard bench for rv_multicycle_ctrl with an instruction-level reference model.
module tb_rv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Comparison = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCUpdate, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUCtrl, state_o;
`ifdef RVCTRL_PERF_COUNTERS_EN
    logic [31:0] cycle_count, instret_count;
`endif

    rv_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Comparison(Comparison), .mem_ready(mem_ready),
        .PCUpdate(PCUpdate), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUCtrl(ALUCtrl), .illegal_instr(illegal_instr),
        .state_o(state_o)
`ifdef RVCTRL_PERF_COUNTERS_EN
        , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcu, pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm;
        logic [3:0] alu;
    } outv_t;

    typedef struct packed {
        outv_t       o;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JAL = 5,
                   K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILLOP = 9, K_ILLBR = 10;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc_m = 0;
    logic [31:0] ret_m = 0;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0010011, 7'b1100111: imm_of = 3'd0;
            7'b0100011:                         imm_of = 3'd1;
            7'b1100011:                         imm_of = 3'd2;
            7'b0110111, 7'b0010111:             imm_of = 3'd3;
            7'b1101111:                         imm_of = 3'd4;
            default:                            imm_of = 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] arith_of(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] tbl [8];
        tbl = '{4'b0010, 4'b1000, 4'b0100, 4'b0011, 4'b1001, 4'b1010, 4'b0001, 4'b0000};
        arith_of = tbl[f3];
        if (f3 == 3'd0 && is_r && f7) arith_of = 4'b0110;
        if (f3 == 3'd5 && f7) arith_of = 4'b1011;
    endfunction

    function automatic logic [3:0] branch_of(input logic [2:0] f3);
        logic [3:0] tbl [8];
        tbl = '{4'b1100, 4'b1101, 4'b0010, 4'b0010, 4'b1110, 4'b1111, 4'b0101, 4'b0111};
        branch_of = tbl[f3];
    endfunction

    function automatic bit legal_op(input logic [6:0] o);
        legal_op = o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    function automatic outv_t expect_out(input int st, input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7, input logic cmp, input logic mr);
        outv_t e;
        e = '0;
        e.st = 4'(st);
        e.alu = 4'b0010;
        e.imm = imm_of(o);
        case (st)
            0:  begin e.sb = 2; e.rs = 2; e.irw = mr; e.pcu = mr; end
            1:  begin e.sa = 1; e.sb = 1; end
            2:  begin e.sa = 2; e.sb = 1; end
            3:  e.adr = 1;
            4:  begin e.rs = 1; e.rw = 1; end
            5:  begin e.adr = 1; e.mw = 1; end
            6:  begin e.sa = 2; e.alu = arith_of(f3, f7, 1'b1); end
            7:  begin e.sa = 2; e.sb = 1; e.alu = arith_of(f3, f7, 1'b0); end
            8:  e.rw = 1;
            9:  begin e.sa = 2; e.alu = branch_of(f3); e.pcw = cmp; end
            10: begin e.sa = 1; e.sb = 2; e.pcu = 1; end
            11: begin e.sa = 2; e.sb = 1; e.rs = 2; e.pcu = 1; end
            12: begin e.sa = 1; e.sb = 2; e.rs = 2; e.rw = 1; end
            13: begin e.sa = 3; e.sb = 1; end
            14: begin e.sa = 1; e.sb = 1; end
            default: e.ill = 1;
        endcase
        e.pcw = e.pcw | e.pcu;
        return e;
    endfunction

    task automatic drive_cycle(input int st, input logic rst, input logic mr, input int cmp_force,
                               input logic [6:0] o, input logic [2:0] f3, input logic f7);
        exp_t e;
        logic c;
        @(posedge clk);
        #1;
        c = (cmp_force < 0) ? 1'($urandom_range(0, 1)) : 1'(cmp_force);
        reset = rst; mem_ready = mr; Comparison = c;
        op = o; funct3 = f3; funct7b5 = f7;
        e.o = expect_out(st, o, f3, f7, c, mr);
        if (rst) begin
            e.o.pcu = 0; e.o.pcw = 0; e.o.mw = 0; e.o.irw = 0; e.o.rw = 0; e.o.ill = 0;
        end
        e.cyc = cyc_m;
        e.ret = ret_m;
        exp_q.push_back(e);
        if (rst) begin
            cyc_m = 0;
            ret_m = 0;
        end else begin
            cyc_m = cyc_m + 1;
        end
    endtask

    // Builds the instruction's cycle-by-cycle state walk, then plays it (optionally cut short by reset).
    task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7, input int fst,
                             input int mst, input int cmp_force, input int abort_at);
        int   sts[$];
        logic mrs[$];
        logic [6:0] o;
        bit   done;
        case (kind)
            K_R:     o = 7'b0110011;
            K_I:     o = 7'b0010011;
            K_LOAD:  o = 7'b0000011;
            K_STORE: o = 7'b0100011;
            K_BR, K_ILLBR: o = 7'b1100011;
            K_JAL:   o = 7'b1101111;
            K_JALR:  o = 7'b1100111;
            K_LUI:   o = 7'b0110111;
            K_AUIPC: o = 7'b0010111;
            default: begin
                o = 7'b0001111;
                if (abort_at != -2) begin
                    do o = 7'($urandom_range(0, 127)); while (legal_op(o));
                end
            end
        endcase
        for (int i = 0; i < fst; i++) begin sts.push_back(0); mrs.push_back(1'b0); end
        sts.push_back(0); mrs.push_back(1'b1);
        sts.push_back(1); mrs.push_back(1'($urandom_range(0, 1)));
        case (kind)
            K_R:     begin sts.push_back(6);  sts.push_back(8); end
            K_I:     begin sts.push_back(7);  sts.push_back(8); end
            K_JAL:   begin sts.push_back(10); sts.push_back(8); end
            K_JALR:  begin sts.push_back(11); sts.push_back(12); end
            K_LUI:   begin sts.push_back(13); sts.push_back(8); end
            K_AUIPC: begin sts.push_back(14); sts.push_back(8); end
            K_BR:    sts.push_back(9);
            K_LOAD, K_STORE: begin
                sts.push_back(2); mrs.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mst; i++) begin
                    sts.push_back(kind == K_LOAD ? 3 : 5); mrs.push_back(1'b0);
                end
                sts.push_back(kind == K_LOAD ? 3 : 5); mrs.push_back(1'b1);
                if (kind == K_LOAD) sts.push_back(4);
            end
            default: sts.push_back(15);
        endcase
        while (mrs.size() < sts.size()) mrs.push_back(1'($urandom_range(0, 1)));
        done = 1;
        for (int i = 0; i < sts.size(); i++) begin
            drive_cycle(sts[i], i == abort_at, mrs[i], cmp_force, o, f3, f7);
            if (i == abort_at) begin done = 0; break; end
        end
        if (done && kind != K_ILLOP && kind != K_ILLBR) ret_m = ret_m + 1;
    endtask

    always @(negedge clk) begin
        exp_t  e;
        outv_t g;
        g = '{st: state_o, pcu: PCUpdate, pcw: PCWrite, adr: AdrSrc, mw: MemWrite, irw: IRWrite,
              rw: RegWrite, ill: illegal_instr, rs: ResultSrc, sa: ALUSrcA, sb: ALUSrcB,
              imm: ImmSrc, alu: ALUCtrl};
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (g !== e.o) begin
                errors++;
                $display("FAIL outputs t=%0t got=%h want=%h (state %0d/%0d alu %b/%b)",
                         $time, g, e.o, g.st, e.o.st, g.alu, e.o.alu);
            end
`ifdef RVCTRL_PERF_COUNTERS_EN
            checks++;
            if (cycle_count !== e.cyc || instret_count !== e.ret) begin
                errors++;
                $display("FAIL counters t=%0t got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         $time, cycle_count, instret_count, e.cyc, e.ret);
            end
`endif
        end
    end

    initial begin
        int br_f3 [6];
        int kind, f3v, ab;
        br_f3 = '{0, 1, 4, 5, 6, 7};
        // Two cycles of reset, both checked after the first reset edge.
        drive_cycle(0, 1'b1, 1'b1, -1, 7'b0110011, 3'd0, 1'b0);
        drive_cycle(0, 1'b1, 1'b1, -1, 7'b0110011, 3'd0, 1'b0);
        run_instr(K_R, 3'd0, 1'b0, 0, 0, -1, -1);
        run_instr(K_LOAD, 3'd2, 1'b0, 0, 0, -1, -1);
        run_instr(K_BR, 3'd0, 1'b0, 0, 0, -1, -1);
        run_instr(K_R, 3'd0, 1'b1, 0, 0, -1, -1);
        run_instr(K_LOAD, 3'd2, 1'b0, 0, 3, -1, -1);
        run_instr(K_BR, 3'd6, 1'b0, 0, 0, 1, -1);
        run_instr(K_BR, 3'd6, 1'b0, 0, 0, 0, -1);
        run_instr(K_ILLOP, 3'd0, 1'b0, 0, 0, -1, -2);
        run_instr(K_ILLBR, 3'd2, 1'b0, 0, 0, -1, -1);
        run_instr(K_STORE, 3'd2, 1'b0, 2, 2, -1, -1);
        run_instr(K_I, 3'd0, 1'b1, 1, 0, -1, -1);
        run_instr(K_JALR, 3'd0, 1'b0, 0, 0, -1, 3);
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 10);
            f3v = (kind == K_BR) ? br_f3[$urandom_range(0, 5)]
                : (kind == K_ILLBR) ? 2 + $urandom_range(0, 1) : $urandom_range(0, 7);
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(kind, 3'(f3v), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, -1, ab);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
